// File: rtl/ssm_tile_streamer.sv
// Buffers one token's B/C/h_prev vectors plus scalars and streams them as packed tiles, then captures y_final.
// Tile 0 appears one cycle after start, II=1 under ready; the tile register holds while valid && !ready.
module ssm_tile_streamer #(
  parameter  int DW      = 16,
  parameter  int N_TILE  = 16,
  parameter  int N_TOTAL = 128,
  parameter  int AW      = $clog2(N_TOTAL),
  localparam int TILES   = N_TOTAL / N_TILE,
  localparam int TW      = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [1:0]           wr_sel_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [DW-1:0]        wr_data_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DW-1:0]        dt_o,
  output logic [DW-1:0]        dA_o,
  output logic [DW-1:0]        x_o,
  output logic [DW-1:0]        D_o,
  output logic                 tile_valid_o,
  input  logic                 tile_ready_i,
  output logic [TW-1:0]        tile_idx_o,
  output logic [N_TILE*DW-1:0] B_tile_o,
  output logic [N_TILE*DW-1:0] C_tile_o,
  output logic [N_TILE*DW-1:0] hprev_tile_o,
  input  logic [DW-1:0]        y_final_i,
  input  logic                 y_final_valid_i,
  output logic [DW-1:0]        y_result_o
);

  localparam int CW = $clog2(TILES + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_Y} state_t;

  state_t state;

  logic [DW-1:0] b_mem [N_TOTAL];
  logic [DW-1:0] c_mem [N_TOTAL];
  logic [DW-1:0] h_mem [N_TOTAL];

  // Index of the next tile to load into the output register (reaches TILES when all are loaded).
  logic [CW-1:0]        load_idx;
  logic [N_TILE*DW-1:0] b_next;
  logic [N_TILE*DW-1:0] c_next;
  logic [N_TILE*DW-1:0] h_next;
  logic                 wr_ok;
  logic                 tiles_left;
  logic                 handshake;
  logic                 last_handshake;

  assign wr_ok          = wr_en_i && !busy_o;
  assign tiles_left     = load_idx < CW'(TILES);
  assign handshake      = tile_valid_o && tile_ready_i;
  assign last_handshake = handshake && (tile_idx_o == TW'(TILES - 1));

  always_comb begin
    b_next = '0;
    c_next = '0;
    h_next = '0;
    for (int j = 0; j < N_TILE; j++) begin
      b_next[DW*j +: DW] = b_mem[AW'(int'(load_idx) * N_TILE + j)];
      c_next[DW*j +: DW] = c_mem[AW'(int'(load_idx) * N_TILE + j)];
      h_next[DW*j +: DW] = h_mem[AW'(int'(load_idx) * N_TILE + j)];
    end
  end

  // Vector storage deliberately has no reset so contents survive an aborted run.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (wr_sel_i)
        2'd0:    b_mem[wr_addr_i] <= wr_data_i;
        2'd1:    c_mem[wr_addr_i] <= wr_data_i;
        2'd2:    h_mem[wr_addr_i] <= wr_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      dt_o         <= '0;
      dA_o         <= '0;
      x_o          <= '0;
      D_o          <= '0;
      tile_valid_o <= 1'b0;
      tile_idx_o   <= '0;
      B_tile_o     <= '0;
      C_tile_o     <= '0;
      hprev_tile_o <= '0;
      y_result_o   <= '0;
      load_idx     <= '0;
    end else begin
      done_o <= 1'b0;

      if (wr_ok && wr_sel_i == 2'd3) begin
        case (wr_addr_i[1:0])
          2'd0:    dt_o <= wr_data_i;
          2'd1:    dA_o <= wr_data_i;
          2'd2:    x_o  <= wr_data_i;
          default: D_o  <= wr_data_i;
        endcase
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= STREAM;
            busy_o   <= 1'b1;
            load_idx <= '0;
          end
        end
        STREAM: begin
          if (!tile_valid_o || tile_ready_i) begin
            if (tiles_left) begin
              tile_valid_o <= 1'b1;
              tile_idx_o   <= TW'(load_idx);
              B_tile_o     <= b_next;
              C_tile_o     <= c_next;
              hprev_tile_o <= h_next;
              load_idx     <= load_idx + 1'b1;
            end else begin
              tile_valid_o <= 1'b0;
            end
          end
          if (last_handshake) begin
            state <= WAIT_Y;
          end
        end
        WAIT_Y: begin
          if (y_final_valid_i) begin
            y_result_o <= y_final_i;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssm_tile_streamer.sv
// Randomized bench for ssm_tile_streamer with an array-level model of the tile contents.
module tb_ssm_tile_streamer;

  localparam int DW = 16;
  localparam int NT = 16;
  localparam int NTOT = 128;
  localparam int TILES = 8;
  localparam int TBW = NT * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           wr_en_i = 1'b0;
  logic [1:0]     wr_sel_i = '0;
  logic [6:0]     wr_addr_i = '0;
  logic [DW-1:0]  wr_data_i = '0;
  logic           start_i = 1'b0;
  logic           tile_ready_i = 1'b0;
  logic [DW-1:0]  y_final_i = '0;
  logic           y_final_valid_i = 1'b0;

  logic           busy_o, done_o, tile_valid_o;
  logic [DW-1:0]  dt_o, dA_o, x_o, D_o, y_result_o;
  logic [2:0]     tile_idx_o;
  logic [TBW-1:0] B_tile_o, C_tile_o, hprev_tile_o;

  logic           s_busy, s_done, s_valid;
  logic [DW-1:0]  s_dt, s_dA, s_x, s_D, s_yres;
  logic [0:0]     s_idx;
  logic [TBW-1:0] s_b, s_c, s_h;

  ssm_tile_streamer #(.DW(DW), .N_TILE(NT), .N_TOTAL(NTOT)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .dt_o(dt_o), .dA_o(dA_o), .x_o(x_o), .D_o(D_o), .tile_valid_o(tile_valid_o),
    .tile_ready_i(tile_ready_i), .tile_idx_o(tile_idx_o), .B_tile_o(B_tile_o),
    .C_tile_o(C_tile_o), .hprev_tile_o(hprev_tile_o), .y_final_i(y_final_i),
    .y_final_valid_i(y_final_valid_i), .y_result_o(y_result_o)
  );

  ssm_tile_streamer #(.DW(DW), .N_TILE(NT), .N_TOTAL(16)) dut_small (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_addr_i(wr_addr_i[3:0]),
    .wr_data_i(wr_data_i), .start_i(start_i), .busy_o(s_busy), .done_o(s_done),
    .dt_o(s_dt), .dA_o(s_dA), .x_o(s_x), .D_o(s_D), .tile_valid_o(s_valid),
    .tile_ready_i(tile_ready_i), .tile_idx_o(s_idx), .B_tile_o(s_b),
    .C_tile_o(s_c), .hprev_tile_o(s_h), .y_final_i(y_final_i),
    .y_final_valid_i(y_final_valid_i), .y_result_o(s_yres)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: plain arrays indexed by element, plus a run-in-progress flag.
  logic [DW-1:0] mb [NTOT];
  logic [DW-1:0] mc [NTOT];
  logic [DW-1:0] mh [NTOT];
  logic [DW-1:0] ms [4];
  bit            model_busy = 1'b0;

  int             hs_idx [$];
  int             hs_cyc [$];
  logic [TBW-1:0] hs_b [$];
  logic [TBW-1:0] hs_c [$];
  logic [TBW-1:0] hs_h [$];
  int             stall_err;

  function automatic logic [TBW-1:0] exp_tile(input int sel, input int t);
    logic [TBW-1:0] v;
    v = '0;
    for (int j = 0; j < NT; j++) begin
      case (sel)
        0:       v[DW*j +: DW] = mb[t*NT + j];
        1:       v[DW*j +: DW] = mc[t*NT + j];
        default: v[DW*j +: DW] = mh[t*NT + j];
      endcase
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input int addr, input logic [DW-1:0] d);
    wr_en_i = 1'b1; wr_sel_i = sel[1:0]; wr_addr_i = addr[6:0]; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    if (!model_busy) begin
      case (sel)
        0:       mb[addr] = d;
        1:       mc[addr] = d;
        2:       mh[addr] = d;
        default: ms[addr % 4] = d;
      endcase
    end
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    model_busy = 1'b1;
  endtask

  // Drives tile_ready_i (0: always 1, 1: 1,0,0,1,0,1 repeating, 2: random) and records handshakes.
  task automatic run_stream(input int mode);
    int cyc;
    bit r, prev_stall;
    logic [2:0] p_idx;
    logic [TBW-1:0] p_b, p_c, p_h;
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    hs_idx.delete(); hs_cyc.delete(); hs_b.delete(); hs_c.delete(); hs_h.delete();
    stall_err = 0; prev_stall = 1'b0; cyc = 0;
    p_idx = '0; p_b = '0; p_c = '0; p_h = '0;
    while (hs_idx.size() < TILES && cyc < 400) begin
      if (prev_stall && (!tile_valid_o || tile_idx_o !== p_idx || B_tile_o !== p_b ||
                         C_tile_o !== p_c || hprev_tile_o !== p_h))
        stall_err++;
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 6] != 0;
        default: r = $urandom_range(0, 1) == 1;
      endcase
      tile_ready_i = r;
      if (tile_valid_o && r) begin
        hs_idx.push_back(int'(tile_idx_o)); hs_cyc.push_back(cyc);
        hs_b.push_back(B_tile_o); hs_c.push_back(C_tile_o); hs_h.push_back(hprev_tile_o);
      end
      prev_stall = tile_valid_o && !r;
      p_idx = tile_idx_o; p_b = B_tile_o; p_c = C_tile_o; p_h = hprev_tile_o;
      tick();
      cyc++;
    end
    tile_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || tile_valid_o !== 1'b0 || tile_idx_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b valid=%b idx=%0d, required all 0", busy_o, done_o, tile_valid_o, tile_idx_o);
    end
    n_checks++;
    if (B_tile_o !== '0 || C_tile_o !== '0 || hprev_tile_o !== '0) begin
      n_fail++; $display("FAIL reset_tiles: tile buses not zero");
    end
    n_checks++;
    if (dt_o !== 16'h0 || dA_o !== 16'h0 || x_o !== 16'h0 || D_o !== 16'h0 || y_result_o !== 16'h0) begin
      n_fail++; $display("FAIL reset_scalars: dt=%h dA=%h x=%h D=%h y=%h, required 0", dt_o, dA_o, x_o, D_o, y_result_o);
    end
    for (int i = 0; i < 4; i++) ms[i] = '0;
    model_busy = 1'b0;
  endtask

  task automatic test_load();
    for (int i = 0; i < NTOT; i++) begin
      wr(0, i, 16'h1000 + 16'(i));
      wr(1, i, 16'h2000 + 16'(i));
      wr(2, i, 16'h3000 + 16'(i));
    end
    wr(3, 0, 16'h3C00); wr(3, 1, 16'h3800); wr(3, 2, 16'h4000); wr(3, 3, 16'h3400);
    n_checks++;
    if (dt_o !== 16'h3C00 || dA_o !== 16'h3800 || x_o !== 16'h4000 || D_o !== 16'h3400) begin
      n_fail++; $display("FAIL scalar_load: dt=%h dA=%h x=%h D=%h, required 3c00 3800 4000 3400", dt_o, dA_o, x_o, D_o);
    end
    y_final_valid_i = 1'b1; y_final_i = 16'hDEAD;
    tick();
    y_final_valid_i = 1'b0;
    n_checks++;
    if (done_o !== 1'b0 || y_result_o !== 16'h0) begin
      n_fail++; $display("FAIL y_in_idle: done=%b y=%h, required 0 0000", done_o, y_result_o);
    end
  endtask

  task automatic test_stream_ready();
    start_run();
    n_checks++;
    if (busy_o !== 1'b1 || tile_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL start_latency: busy=%b valid=%b, required 1 0", busy_o, tile_valid_o);
    end
    run_stream(0);
    n_checks++;
    if (hs_idx.size() !== TILES) begin
      n_fail++; $display("FAIL full_rate_count: %0d handshakes, required %0d", hs_idx.size(), TILES);
    end
    for (int t = 0; t < hs_idx.size(); t++) begin
      n_checks++;
      if (hs_idx[t] !== t || hs_cyc[t] !== t + 1 || hs_b[t] !== exp_tile(0, t) ||
          hs_c[t] !== exp_tile(1, t) || hs_h[t] !== exp_tile(2, t)) begin
        n_fail++; $display("FAIL full_rate_tile%0d: idx=%0d cyc=%0d lane0=%h, required idx=%0d cyc=%0d lane0=%h",
                           t, hs_idx[t], hs_cyc[t], hs_b[t][15:0], t, t + 1, exp_tile(0, t) >> 0);
      end
    end
    n_checks++;
    if (hs_b.size() == TILES && (hs_b[0][15:0] !== 16'h1000 || hs_b[7][255:240] !== 16'h107F)) begin
      n_fail++; $display("FAIL known_lanes: t0l0=%h t7l15=%h, required 1000 107f", hs_b[0][15:0], hs_b[7][255:240]);
    end
    n_checks++;
    if (tile_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL wait_y_entry: valid=%b busy=%b, required 0 1", tile_valid_o, busy_o);
    end
    y_final_valid_i = 1'b1; y_final_i = 16'h5555;
    tick();
    y_final_valid_i = 1'b0; model_busy = 1'b0;
    n_checks++;
    if (done_o !== 1'b1 || y_result_o !== 16'h5555 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL y_capture: done=%b y=%h busy=%b, required 1 5555 0", done_o, y_result_o, busy_o);
    end
    tick();
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: done=%b one cycle later, required 0", done_o);
    end
  endtask

  task automatic test_backpressure();
    int dones;
    start_run();
    y_final_valid_i = 1'b1; y_final_i = 16'hABCD;
    tick();
    y_final_valid_i = 1'b0;
    wr(0, 0, 16'hFFFF);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_checks++;
    if (done_o !== 1'b0 || y_result_o !== 16'h5555) begin
      n_fail++; $display("FAIL y_in_stream: done=%b y=%h, required 0 5555", done_o, y_result_o);
    end
    run_stream(1);
    n_checks++;
    if (hs_idx.size() !== TILES || stall_err !== 0) begin
      n_fail++; $display("FAIL stall_run: %0d handshakes, %0d unstable stalls, required %0d and 0", hs_idx.size(), stall_err, TILES);
    end
    for (int t = 0; t < hs_idx.size(); t++) begin
      n_checks++;
      if (hs_idx[t] !== t || hs_b[t] !== exp_tile(0, t) || hs_c[t] !== exp_tile(1, t) || hs_h[t] !== exp_tile(2, t)) begin
        n_fail++; $display("FAIL stall_tile%0d: idx=%0d lane0=%h, required idx=%0d", t, hs_idx[t], hs_b[t][15:0], t);
      end
    end
    n_checks++;
    if (hs_b.size() > 0 && hs_b[0][15:0] !== 16'h1000) begin
      n_fail++; $display("FAIL busy_write_drop: lane0=%h, required 1000", hs_b[0][15:0]);
    end
    y_final_valid_i = 1'b1; y_final_i = 16'h1234;
    tick();
    y_final_valid_i = 1'b0; model_busy = 1'b0;
    dones = int'(done_o);
    n_checks++;
    if (y_result_o !== 16'h1234 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL y_after_ignore: y=%h busy=%b, required 1234 0", y_result_o, busy_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      dones += int'(done_o);
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++; $display("FAIL done_count: %0d pulses, required 1", dones);
    end
  endtask

  task automatic test_random_ready(input logic [DW-1:0] yv);
    start_run();
    run_stream(2);
    n_checks++;
    if (hs_idx.size() !== TILES || stall_err !== 0) begin
      n_fail++; $display("FAIL rand_run: %0d handshakes, %0d unstable stalls, required %0d and 0", hs_idx.size(), stall_err, TILES);
    end
    for (int t = 0; t < hs_idx.size(); t++) begin
      n_checks++;
      if (hs_idx[t] !== t || hs_b[t] !== exp_tile(0, t) || hs_c[t] !== exp_tile(1, t) || hs_h[t] !== exp_tile(2, t)) begin
        n_fail++; $display("FAIL rand_tile%0d: idx=%0d lane0=%h, required idx=%0d lane0=%h", t, hs_idx[t], hs_b[t][15:0], t, mb[t*NT]);
      end
    end
    n_checks++;
    if (hs_b.size() > 0 && hs_b[0][15:0] !== mb[0]) begin
      n_fail++; $display("FAIL rand_lane0: %h, required %h", hs_b[0][15:0], mb[0]);
    end
    y_final_valid_i = 1'b1; y_final_i = yv;
    tick();
    y_final_valid_i = 1'b0; model_busy = 1'b0;
    n_checks++;
    if (done_o !== 1'b1 || y_result_o !== yv) begin
      n_fail++; $display("FAIL rand_y: done=%b y=%h, required 1 %h", done_o, y_result_o, yv);
    end
  endtask

  task automatic test_reset_midrun();
    int bad;
    start_run();
    tile_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tile_ready_i = 1'b0;
    n_checks++;
    if (tile_valid_o !== 1'b1 || tile_idx_o !== 3'd3) begin
      n_fail++; $display("FAIL pre_abort: valid=%b idx=%0d, required 1 3", tile_valid_o, tile_idx_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ms[i] = '0;
    model_busy = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || tile_valid_o !== 1'b0 || tile_idx_o !== 3'd0 || B_tile_o !== '0 ||
        C_tile_o !== '0 || hprev_tile_o !== '0 || dt_o !== 16'h0 || D_o !== 16'h0 || y_result_o !== 16'h0) begin
      n_fail++; $display("FAIL abort_outputs: busy=%b valid=%b idx=%0d dt=%h y=%h, required all 0", busy_o, tile_valid_o, tile_idx_o, dt_o, y_result_o);
    end
    bad = 0;
    tile_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_o !== 1'b0 || tile_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    tile_ready_i = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
    end
    test_random_ready(16'h0F0F);
  endtask

  task automatic test_random_data();
    int sel, addr;
    logic [DW-1:0] d;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 3);
      addr = (sel == 3) ? $urandom_range(0, 3) : $urandom_range(0, NTOT - 1);
      d = 16'($urandom);
      wr(sel, addr, d);
    end
    n_checks++;
    if (dt_o !== ms[0] || dA_o !== ms[1] || x_o !== ms[2] || D_o !== ms[3]) begin
      n_fail++; $display("FAIL rand_scalars: dt=%h dA=%h x=%h D=%h, required %h %h %h %h", dt_o, dA_o, x_o, D_o, ms[0], ms[1], ms[2], ms[3]);
    end
    d = 16'($urandom);
    addr = $urandom_range(0, NTOT - 1);
    wr_en_i = 1'b1; wr_sel_i = 2'd1; wr_addr_i = addr[6:0]; wr_data_i = d; start_i = 1'b1;
    tick();
    wr_en_i = 1'b0; start_i = 1'b0;
    mc[addr] = d;
    model_busy = 1'b1;
    run_stream(2);
    n_checks++;
    if (hs_idx.size() !== TILES) begin
      n_fail++; $display("FAIL same_cycle_run: %0d handshakes, required %0d", hs_idx.size(), TILES);
    end
    for (int t = 0; t < hs_idx.size(); t++) begin
      n_checks++;
      if (hs_idx[t] !== t || hs_b[t] !== exp_tile(0, t) || hs_c[t] !== exp_tile(1, t) || hs_h[t] !== exp_tile(2, t)) begin
        n_fail++; $display("FAIL same_cycle_tile%0d: idx=%0d, required %0d with model data", t, hs_idx[t], t);
      end
    end
    y_final_valid_i = 1'b1; y_final_i = 16'h7E57;
    tick();
    y_final_valid_i = 1'b0; model_busy = 1'b0;
  endtask

  task automatic test_single_tile();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(0, i, 16'($urandom)); wr(1, i, 16'($urandom)); wr(2, i, 16'($urandom));
    end
    start_run();
    n_checks++;
    if (s_busy !== 1'b1 || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_start: busy=%b valid=%b, required 1 0", s_busy, s_valid);
    end
    tile_ready_i = 1'b1;
    tick();
    n_checks++;
    if (s_valid !== 1'b1 || s_idx !== 1'b0 || s_b !== exp_tile(0, 0) || s_c !== exp_tile(1, 0) || s_h !== exp_tile(2, 0)) begin
      n_fail++; $display("FAIL single_tile: valid=%b idx=%0d lane0=%h, required 1 0 %h", s_valid, s_idx, s_b[15:0], mb[0]);
    end
    tick();
    tile_ready_i = 1'b0;
    n_checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b1) begin
      n_fail++; $display("FAIL single_wait_y: valid=%b busy=%b, required 0 1", s_valid, s_busy);
    end
    y_final_valid_i = 1'b1; y_final_i = 16'h4242;
    tick();
    y_final_valid_i = 1'b0;
    n_checks++;
    if (s_done !== 1'b1 || s_yres !== 16'h4242 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_y: done=%b y=%h busy=%b, required 1 4242 0", s_done, s_yres, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream_ready();
    test_backpressure();
    test_random_ready(16'($urandom));
    test_reset_midrun();
    test_random_data();
    test_random_ready(16'($urandom));
    test_single_tile();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
